// File: rtl/seq_mac_unit.sv
// Iterative shift-add multiply-accumulate, signed/unsigned, saturating; result WIDTH+1 edges after accept.
// Holds result in DONE until out_ready; in_ready only in IDLE, so operands are not taken while busy.
module seq_mac_unit #(
   parameter int WIDTH = 8,
   parameter int ACC_W = 2*WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic             signed_mode,
   input  logic             accumulate,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] result,
   output logic             overflow
);
   localparam int PW    = 2*WIDTH;
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH-1);

   typedef enum logic [1:0] {IDLE, MULT, ACC, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q, b_q;
   logic             sm_q, accum_q;
   logic [PW-1:0]    prod_q;
   logic [CNT_W-1:0] cnt_q;
   logic [ACC_W-1:0] acc_q, result_q;
   logic             ovf_q;

   logic [PW-1:0]    a_ext, a_shift, prod_nxt;
   logic [ACC_W:0]   prod_wide, acc_wide, sum;
   logic [ACC_W-1:0] sat_val;
   logic             sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = MULT;
         MULT:    if (cnt_q == LAST_BIT) state_nxt = ACC;
         ACC:     state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign result    = result_q;
   assign overflow  = ovf_q;

   // The MSB of a two's-complement multiplier carries negative weight, hence the subtract.
   always_comb begin
      a_ext    = {{WIDTH{sm_q & a_q[WIDTH-1]}}, a_q};
      a_shift  = a_ext << cnt_q;
      prod_nxt = prod_q;
      if (b_q[cnt_q]) begin
         if (sm_q && (cnt_q == LAST_BIT)) prod_nxt = prod_q - a_shift;
         else                             prod_nxt = prod_q + a_shift;
      end
   end

   // One guard bit is enough: both addends fit in ACC_W bits in either mode.
   always_comb begin
      prod_wide = {{(ACC_W+1-PW){sm_q & prod_q[PW-1]}}, prod_q};
      acc_wide  = accum_q ? {sm_q & acc_q[ACC_W-1], acc_q} : '0;
      sum       = acc_wide + prod_wide;
      sat       = 1'b0;
      sat_val   = sum[ACC_W-1:0];
      if (sm_q) begin
         if (sum[ACC_W] != sum[ACC_W-1]) begin
            sat     = 1'b1;
            sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
         end
      end else if (sum[ACC_W]) begin
         sat     = 1'b1;
         sat_val = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sm_q     <= 1'b0;
         accum_q  <= 1'b0;
         prod_q   <= '0;
         cnt_q    <= '0;
         acc_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= multiplicand;
                  b_q     <= multiplier;
                  sm_q    <= signed_mode;
                  accum_q <= accumulate;
                  prod_q  <= '0;
                  cnt_q   <= '0;
               end
            end
            MULT: begin
               prod_q <= prod_nxt;
               cnt_q  <= cnt_q + CNT_W'(1);
            end
            ACC: begin
               acc_q    <= sat_val;
               result_q <= sat_val;
               ovf_q    <= sat;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_mac_unit.sv
// Directed bench for seq_mac_unit at WIDTH=8, ACC_W=16.
module tb_seq_mac_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  multiplicand;
   logic [7:0]  multiplier;
   logic        signed_mode;
   logic        accumulate;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   seq_mac_unit #(.WIDTH(8), .ACC_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .signed_mode  (signed_mode),
      .accumulate   (accumulate),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   // Issue one operation from IDLE (called #1 after an edge); returns result, overflow and latency.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic acc,
                         input logic rel_out, output logic [15:0] res, output logic ovf, output int lat);
      multiplicand = a;
      multiplier   = b;
      signed_mode  = sm;
      accumulate   = acc;
      in_valid     = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL op_timeout: out_valid=%b required 1 after %0d cycles", out_valid, lat);
      end
      res = result;
      ovf = overflow;
      if (rel_out) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      multiplicand = '0; multiplier = '0; signed_mode = 1'b0; accumulate = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
      checks++;
      if (result !== 16'h0000 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: result=%h overflow=%b required 0000 0", result, overflow);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_products();
      logic [7:0]  ta [4] = '{8'd3, 8'h80, 8'hFF, 8'd127};
      logic [7:0]  tb [4] = '{8'hFB, 8'h80, 8'hFF, 8'h80};
      logic        ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [15:0] te [4] = '{16'hFFF1, 16'h4000, 16'hFE01, 16'hC080};
      logic [15:0] r;
      logic        o;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], ts[i], 1'b0, 1'b1, r, o, lat);
         checks++;
         if (r !== te[i] || o !== 1'b0) begin
            errors++;
            $display("FAIL product_%0d: result=%h overflow=%b required %h 0", i, r, o, te[i]);
         end
         if (i == 0) begin
            checks++;
            if (lat != 9) begin
               errors++;
               $display("FAIL latency: out_valid after %0d edges required 9", lat);
            end
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake_in_ready_%0d: in_ready=%b required 1", i, in_ready);
         end
      end
   endtask

   task automatic test_signed_sat();
      logic [15:0] e1 [3] = '{16'h3F01, 16'h7E02, 16'h7FFF};
      logic        o1 [3] = '{1'b0, 1'b0, 1'b1};
      logic [15:0] e2 [3] = '{16'hC080, 16'h8100, 16'h8000};
      logic [15:0] r;
      logic        o;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         run_op(8'd127, 8'd127, 1'b1, (i != 0), 1'b1, r, o, lat);
         checks++;
         if (r !== e1[i] || o !== o1[i]) begin
            errors++;
            $display("FAIL sat_pos_%0d: result=%h overflow=%b required %h %b", i, r, o, e1[i], o1[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         run_op(8'h80, 8'd127, 1'b1, (i != 0), 1'b1, r, o, lat);
         checks++;
         if (r !== e2[i] || o !== o1[i]) begin
            errors++;
            $display("FAIL sat_neg_%0d: result=%h overflow=%b required %h %b", i, r, o, e2[i], o1[i]);
         end
      end
   endtask

   task automatic test_unsigned_sat();
      logic [15:0] r;
      logic        o;
      int          lat;
      run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, r, o, lat);
      checks++;
      if (r !== 16'hFE01 || o !== 1'b0) begin
         errors++;
         $display("FAIL usat_first: result=%h overflow=%b required fe01 0", r, o);
      end
      run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, r, o, lat);
      checks++;
      if (r !== 16'hFFFF || o !== 1'b1) begin
         errors++;
         $display("FAIL usat_second: result=%h overflow=%b required ffff 1", r, o);
      end
   endtask

   task automatic test_back_pressure();
      int busy_bad = 0;
      int hold_bad = 0;
      multiplicand = 8'd10; multiplier = 8'd20; signed_mode = 1'b0; accumulate = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      multiplicand = 8'hFF; multiplier = 8'hFF; signed_mode = 1'b1; accumulate = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (in_ready !== 1'b0) busy_bad++;
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL busy_in_ready: in_ready high in %0d busy cycles required 0", busy_bad);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h00C8) begin
         errors++;
         $display("FAIL bp_result: out_valid=%b result=%h required 1 00c8", out_valid, result);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || result !== 16'h00C8 || in_ready !== 1'b0) hold_bad++;
      end
      checks++;
      if (hold_bad != 0) begin
         errors++;
         $display("FAIL bp_hold: %0d unstable cycles required 0 (result=%h)", hold_bad, result);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_early_ready();
      logic [15:0] r;
      logic        o;
      int          lat;
      out_ready = 1'b1;
      run_op(8'd7, 8'd6, 1'b0, 1'b0, 1'b0, r, o, lat);
      checks++;
      if (lat != 9 || r !== 16'd42) begin
         errors++;
         $display("FAIL early_ready: latency=%0d result=%h required 9 002a", lat, r);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL early_ready_idle: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      logic        o;
      int          lat;
      run_op(8'd5, 8'd5, 1'b0, 1'b0, 1'b1, r, o, lat);
      checks++;
      if (r !== 16'd25) begin
         errors++;
         $display("FAIL prime_acc: result=%h required 0019", r);
      end
      multiplicand = 8'd100; multiplier = 8'd100; signed_mode = 1'b0; accumulate = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 16'h0000 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b result=%h in_ready=%b required 0 0000 1",
                  out_valid, result, in_ready);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(8'd2, 8'd3, 1'b0, 1'b1, 1'b1, r, o, lat);
      checks++;
      if (r !== 16'd6 || o !== 1'b0) begin
         errors++;
         $display("FAIL acc_cleared: result=%h overflow=%b required 0006 0", r, o);
      end
   endtask

   initial begin
      test_reset();
      test_products();
      test_signed_sat();
      test_unsigned_sat();
      test_back_pressure();
      test_early_ready();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_mac_unit.md
# seq_mac_unit

Parametrised iterative shift-add multiply-accumulate unit for the neural-network datapath. It generalises the fixed 8×8 sequential multiplier in three ways: configurable operand and accumulator widths, selectable signed or unsigned mode, and an optional saturating accumulate. Operands are captured through a valid/ready handshake and the result is returned through a second valid/ready handshake. It sits between the weight/activation fetch logic and the neuron output register.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2)
- ACC_W, 2*WIDTH, accumulator and result width (must be ≥ 2*WIDTH)

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  unit idle and able to accept operands
- multiplicand  input  WIDTH  operand A
- multiplier  input  WIDTH  operand B
- signed_mode  input  1  1 = two's complement, 0 = unsigned; sampled with the operands
- accumulate  input  1  1 = add product to held accumulator, 0 = start from zero; sampled with the operands
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- result  output  ACC_W  saturated accumulator value
- overflow  output  1  saturation occurred on this operation

## Operation
- FSM states: IDLE, MULT, ACC, DONE.
- in_ready = (state == IDLE). in_valid is ignored in all other states.
- IDLE:
  - When in_valid && in_ready, latch multiplicand, multiplier, signed_mode and accumulate.
  - Clear the partial product, load bit counter = 0, go to MULT.
  - Live operand inputs are never used after the capture edge.
- MULT: one multiplier bit per cycle, LSB first.
  - The shifted multiplicand is sign-extended to 2*WIDTH in signed mode and zero-extended in unsigned mode.
  - For bits 0..WIDTH-2, add the shifted multiplicand if the bit is 1.
  - For bit WIDTH-1: signed mode subtracts the shifted multiplicand; unsigned mode adds it.
  - After bit WIDTH-1, go to ACC.
- ACC:
  - Compute sum = (accumulate ? acc : 0) + product, with ACC_W+1-bit internal width.
  - Signed mode: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Unsigned mode: clamp to [0, 2^ACC_W-1].
  - overflow = 1 iff a clamp applied.
  - Write the clamped value to both acc and result. Go to DONE.
- DONE: out_valid = 1. On out_ready, go to IDLE.
- Held accumulator contents are interpreted in the mode of the current operation. Mixing modes within one accumulation chain is the caller's responsibility.
- The product itself is exact in 2*WIDTH bits in both modes (signed -2^(WIDTH-1)·-2^(WIDTH-1) included), so with accumulate = 0 no clamp ever occurs.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE; acc, result, partial product and counter = 0; overflow = 0; out_valid = 0.
  - in_ready = 1 from IDLE.
- Reset mid-operation aborts immediately. The in-flight result is discarded and the accumulator is cleared.
- Latency, counting the accept edge as edge 0:
  - MULT occupies edges 1..WIDTH.
  - ACC completes at edge WIDTH+1.
  - out_valid is high from edge WIDTH+1, which is 9 for WIDTH=8.
- result and overflow are stable from edge WIDTH+1 until the next ACC completion, regardless of out_valid.
- out_valid holds, with result unchanged, for as long as out_ready is low.
- Output handshake completes on an edge with out_valid && out_ready. in_ready rises on that same edge.
- The next accept is possible at the following edge. Minimum initiation interval is WIDTH+3 cycles.
- out_ready asserted before DONE has no effect.

## Test plan
- WIDTH=8, ACC_W=16, signed, accumulate=0, 3 × -5 → result 0xFFF1, overflow 0; out_valid first high at edge 9 after accept.
- Signed -128 × -128 → 0x4000. Unsigned 255 × 255 → 0xFE01. Signed 127 × -128 → 0xC080. overflow 0 in all cases.
- Signed 127×127 with accumulate=0, then the same with accumulate=1 → 0x3F01, then 0x7E02; a third accumulate → 0x7FFF, overflow 1. Signed -128×127 three times accumulating → 0xC080, 0x8100, then 0x8000 with overflow 1.
- Unsigned 255×255, then 255×255 with accumulate=1 → 0xFE01, then 0xFFFF with overflow 1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid → out_valid and result stable. Keep in_valid high and change operands during MULT → in_ready stays 0 and the result is unaffected. Release out_ready → in_ready=1 on the next cycle.
- Pulse rst_n low during MULT cycle 4 → out_valid=0, result=0, in_ready=1 immediately. Then 2×3 with accumulate=1 → result 6 (accumulator was cleared).
